// File: rtl/register_file_3r1w_if.sv
// Register-file port bundle: three read ports, one write port and the PC value
// used for R15 reads. The master is the pipeline side, the slave is the register file.
interface register_file_3r1w_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_W   = 8
);
  // Read port addresses and data
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] PA;
  logic [DATA_W-1:0] PB;
  logic [DATA_W-1:0] PD;
  // Write port from MEM/WB
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] PW;
  logic              LE;
  // Already-adjusted PC returned on R15 reads
  logic [PC_W-1:0]   PC_in;

  modport master (
    output RA, RB, RD, RW, PW, LE, PC_in,
    input  PA, PB, PD
  );

  modport slave (
    input  RA, RB, RD, RW, PW, LE, PC_in,
    output PA, PB, PD
  );
endinterface

// File: rtl/register_file_3r1w.sv
// ARM general-purpose register file: R0-R14 are flops, R15 reads return the
// supplied PC. Three combinational read ports with write-before-read bypass and
// one synchronous write port. Clr clears the array asynchronously.
module register_file_3r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_W   = 8
) (
  input logic                  Clk,
  input logic                  Clr,
  register_file_3r1w_if.slave  bus
);

  // The highest address is the PC alias; everything below it is real storage.
  localparam int unsigned          NumRegs = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0]    PcAddr  = '1;
  localparam int unsigned          NumRd   = 3;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];
  logic [NumRegs-1:0] wr_en_oh;
  logic               wr_live;
  logic [DATA_W-1:0]  pc_ext;

  logic [ADDR_W-1:0]  rd_addr [NumRd];
  logic [DATA_W-1:0]  rd_data [NumRd];

  // Write is live only when enabled, out of reset and not aimed at R15.
  assign wr_live = bus.LE && !Clr && (bus.RW != PcAddr);
  assign pc_ext  = DATA_W'(bus.PC_in);

  // One-hot write decode over R0-R14.
  always_comb begin
    wr_en_oh = '0;
    for (int i = 0; i < NumRegs; i++) begin
      wr_en_oh[i] = wr_live && (bus.RW == ADDR_W'(i));
    end
  end

  // Next-state of the array: selected register takes PW, others hold.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = wr_en_oh[i] ? bus.PW : regs_q[i];
    end
  end

  // Register array with asynchronous clear; Clr dominates any pending write.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rd_addr[0] = bus.RA;
  assign rd_addr[1] = bus.RB;
  assign rd_addr[2] = bus.RD;

  // Read muxes: R15 -> PC, matching live write -> PW, else stored value.
  always_comb begin
    for (int p = 0; p < NumRd; p++) begin
      rd_data[p] = '0;
      if (rd_addr[p] == PcAddr) begin
        rd_data[p] = pc_ext;
      end else if (wr_live && (rd_addr[p] == bus.RW)) begin
        rd_data[p] = bus.PW;
      end else begin
        for (int i = 0; i < NumRegs; i++) begin
          if (rd_addr[p] == ADDR_W'(i)) begin
            rd_data[p] = regs_q[i];
          end
        end
      end
    end
  end

  assign bus.PA = rd_data[0];
  assign bus.PB = rd_data[1];
  assign bus.PD = rd_data[2];

endmodule

// File: tb/tb_register_file_3r1w.sv
// Directed bench for register_file_3r1w: reset, write/read, bypass, R15 alias,
// reset-vs-write collision and a full sweep through all three ports.
module tb_register_file_3r1w;

  logic Clk;
  logic Clr;

  register_file_3r1w_if #(.DATA_W(32), .ADDR_W(4), .PC_W(8)) bus ();

  register_file_3r1w #(.DATA_W(32), .ADDR_W(4), .PC_W(8)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a write on the next rising edge, then deassert LE.
  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    @(negedge Clk);
    bus.LE = 1'b1;
    bus.RW = addr;
    bus.PW = data;
    @(posedge Clk);
    #1;
    bus.LE = 1'b0;
  endtask

  task automatic set_rd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    bus.RA = a;
    bus.RB = b;
    bus.RD = d;
    #1;
  endtask

  logic [31:0] exp_val;

  initial begin
    Clr       = 1'b1;
    bus.LE    = 1'b0;
    bus.RW    = 4'd0;
    bus.PW    = '0;
    bus.RA    = 4'd0;
    bus.RB    = 4'd0;
    bus.RD    = 4'd0;
    bus.PC_in = 8'h08;
    repeat (2) @(posedge Clk);
    #1;
    set_rd(4'd0, 4'd14, 4'd15);
    check_eq("rst_pa_r0", bus.PA, 32'h0);
    check_eq("rst_pb_r14", bus.PB, 32'h0);
    check_eq("rst_pd_r15", bus.PD, 32'h0000_0008);
    @(negedge Clk);
    Clr = 1'b0;

    // 1: write R3 then async clear between edges
    write_reg(4'd3, 32'hDEAD_BEEF);
    set_rd(4'd3, 4'd0, 4'd0);
    check_eq("t1_r3_written", bus.PA, 32'hDEAD_BEEF);
    @(negedge Clk);
    Clr = 1'b1;
    #1;
    check_eq("t1_async_clr", bus.PA, 32'h0);
    #1;
    Clr = 1'b0;

    // 2: basic write/read
    write_reg(4'd5, 32'h1234_5678);
    set_rd(4'd5, 4'd5, 4'd5);
    check_eq("t2_pa", bus.PA, 32'h1234_5678);
    check_eq("t2_pb", bus.PB, 32'h1234_5678);
    check_eq("t2_pd", bus.PD, 32'h1234_5678);
    set_rd(4'd4, 4'd6, 4'd5);
    check_eq("t2_r4", bus.PA, 32'h0);
    check_eq("t2_r6", bus.PB, 32'h0);

    // LE=0 must not write
    @(negedge Clk);
    bus.RW = 4'd5;
    bus.PW = 32'hBAD0_BAD0;
    @(posedge Clk);
    #1;
    set_rd(4'd5, 4'd0, 4'd0);
    check_eq("le0_hold", bus.PA, 32'h1234_5678);

    // 3: bypass on all ports at once
    write_reg(4'd7, 32'h1111_1111);
    set_rd(4'd0, 4'd7, 4'd0);
    check_eq("t3_r7_old", bus.PB, 32'h1111_1111);
    @(negedge Clk);
    bus.LE = 1'b1;
    bus.RW = 4'd7;
    bus.PW = 32'h2222_2222;
    set_rd(4'd7, 4'd7, 4'd7);
    check_eq("t3_byp_pa", bus.PA, 32'h2222_2222);
    check_eq("t3_byp_pb", bus.PB, 32'h2222_2222);
    check_eq("t3_byp_pd", bus.PD, 32'h2222_2222);
    set_rd(4'd5, 4'd7, 4'd3);
    check_eq("t3_other_port", bus.PA, 32'h1234_5678);
    @(posedge Clk);
    #1;
    bus.LE = 1'b0;
    #1;
    check_eq("t3_after_edge", bus.PB, 32'h2222_2222);

    // 4: R15 alias ignores writes
    @(negedge Clk);
    bus.PC_in = 8'h08;
    bus.LE    = 1'b1;
    bus.RW    = 4'd15;
    bus.PW    = 32'hFFFF_FFFF;
    set_rd(4'd15, 4'd15, 4'd15);
    check_eq("t4_pd_during", bus.PD, 32'h0000_0008);
    @(posedge Clk);
    #1;
    bus.LE = 1'b0;
    #1;
    check_eq("t4_pd_after", bus.PD, 32'h0000_0008);
    set_rd(4'd5, 4'd7, 4'd3);
    check_eq("t4_r5_kept", bus.PA, 32'h1234_5678);
    check_eq("t4_r7_kept", bus.PB, 32'h2222_2222);
    check_eq("t4_r3_kept", bus.PD, 32'h0);

    // 5: Clr held across a write edge; no bypass while in reset
    @(negedge Clk);
    Clr    = 1'b1;
    bus.LE = 1'b1;
    bus.RW = 4'd2;
    bus.PW = 32'hA5A5_A5A5;
    set_rd(4'd2, 4'd0, 4'd0);
    check_eq("t5_no_byp_in_clr", bus.PA, 32'h0);
    @(posedge Clk);
    #1;
    bus.LE = 1'b0;
    @(negedge Clk);
    Clr = 1'b0;
    #1;
    check_eq("t5_r2_zero", bus.PA, 32'h0);
    set_rd(4'd5, 4'd0, 4'd0);
    check_eq("t5_r5_cleared", bus.PA, 32'h0);

    // 6: sweep R0-R14 through every port
    for (int i = 0; i < 15; i++) begin
      write_reg(4'(i), 32'(i) * 32'h0101_0101);
    end
    for (int i = 0; i < 15; i++) begin
      exp_val = 32'(i) * 32'h0101_0101;
      set_rd(4'(i), 4'(i), 4'(i));
      check_eq($sformatf("t6_pa_r%0d", i), bus.PA, exp_val);
      check_eq($sformatf("t6_pb_r%0d", i), bus.PB, exp_val);
      check_eq($sformatf("t6_pd_r%0d", i), bus.PD, exp_val);
    end
    set_rd(4'd15, 4'd15, 4'd15);
    bus.PC_in = 8'h00;
    #1;
    check_eq("t6_pc00", bus.PA, 32'h0000_0000);
    bus.PC_in = 8'h04;
    #1;
    check_eq("t6_pc04", bus.PB, 32'h0000_0004);
    bus.PC_in = 8'h08;
    #1;
    check_eq("t6_pc08", bus.PD, 32'h0000_0008);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/register_file_3r1w.md
Name: register_file_3r1w

Overview:
- Sixteen-entry, 32-bit ARM general-purpose register file for the ID stage.
- Three combinational read ports feed the ID/EX pipeline register operand inputs PA/PB/PD.
- One synchronous write port is driven by the MEM/WB pipeline register outputs: data, destination register, RF enable.
- R15 is not storage; reading it returns the supplied PC value. Same-cycle write data is bypassed to the read ports.

Parameters:
- DATA_W, 32, width of each register and of every data port.
- ADDR_W, 4, register address width (16 architectural registers).
- PC_W, 8, width of the incoming PC value used for R15 reads.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Clr  input  1  asynchronous, active-high reset.
- RA  input  ADDR_W  read address, port A (instruction bits 19:16).
- RB  input  ADDR_W  read address, port B (instruction bits 3:0).
- RD  input  ADDR_W  read address, port D (instruction bits 15:12, store data).
- PA  output  DATA_W  read data, port A.
- PB  output  DATA_W  read data, port B.
- PD  output  DATA_W  read data, port D.
- RW  input  ADDR_W  write address (MEM/WB destination register).
- PW  input  DATA_W  write data (MEM/WB result).
- LE  input  1  write enable (MEM/WB RF enable).
- PC_in  input  PC_W  current PC value returned on R15 reads; the caller supplies the already-adjusted value.

Behaviour:
- Storage
  - R0–R14 are flops, each DATA_W wide.
  - R15 has no storage.
- Reset
  - Clr=1 clears R0–R14 to 0 immediately, without waiting for Clk.
  - Clr dominates: a write pending on the same edge while Clr=1 is discarded.
  - Reset values of outputs: PA/PB/PD = 0 for any address 0–14, and {zero-ext PC_in} for address 15.
  - Releasing Clr mid-cycle has no effect until the next rising edge.
- Write
  - On the rising edge of Clk with Clr=0, LE=1 and RW≠15, the register at RW takes PW.
  - RW=15 writes are ignored silently; PC updates are owned by the PC register.
  - LE=0 leaves all registers unchanged.
- Read
  - Purely combinational, zero latency, on each of the three ports independently.
  - Address 15 returns PC_in zero-extended to DATA_W.
  - Otherwise a port returns the stored register value, except under the bypass rule below.
- Bypass (write-before-read)
  - If LE=1, RW≠15, Clr=0 and a read address equals RW, that port returns PW in the same cycle.
  - This closes the WB→ID read-after-write window without an extra stall.
  - Bypass applies to any number of ports at once. All three reading RW all return PW.
- Address decode
  - Write decoder is one-hot over 0–14.
  - No X propagation: unknown addresses are not required to be handled; the bench drives only known values.
- Simultaneous events
  - Read and write to different addresses in the same cycle are independent.
  - A read of address 15 while RW=15 and LE=1 returns PC_in, not PW.
- No other state
  - No FSM and no counters beyond the register array.
  - The block never stalls or back-pressures.

Test Plan:
1. Reset clear: write 0xDEADBEEF to R3, then pulse Clr=1 between clock edges → PA with RA=3 reads 0x00000000 immediately, before the next edge.
2. Basic write/read: LE=1, RW=5, PW=0x12345678, one edge, then LE=0 → RA=RB=RD=5 give 0x12345678 on all ports. R4 and R6 still read 0.
3. Bypass: R7 holds 0x11111111. Drive LE=1, RW=7, PW=0x22222222 with RB=7 before the edge → PB=0x22222222 combinationally. After the edge with LE=0, PB is still 0x22222222.
4. R15 handling: PC_in=0x08, then LE=1, RW=15, PW=0xFFFFFFFF, one edge → PD with RD=15 reads 0x00000008, both during and after the write. No R0–R14 value changes.
5. Reset vs write collision: Clr=1 held across an edge with LE=1, RW=2, PW=0xA5A5A5A5 → R2 reads 0 after Clr drops.
6. Sweep: write R0–R14 with value (index×0x01010101) on consecutive edges, then read back all 15 through every port → exact match on every port, and R15 tracks PC_in=0x00, 0x04, 0x08.
